// File: rtl/imem_dmem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM single-port RAM arbiter: state encoding,
// owner codes and the default starvation limit.
package imem_dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/imem_dmem_port_arbiter_pick.sv
// Combinational winner select: MEM has priority unless IF has been starved
// for STARVE_LIMIT consecutive MEM grants, or MEM is not requesting.
module port_arb_pick
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       if_req_i,
  input  logic       mem_req_i,
  input  logic [3:0] starve_cnt_i,
  output logic       grant_o,
  output logic       winner_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic if_forced;

  assign if_forced = if_req_i && (starve_cnt_i == LIMIT);
  assign grant_o   = if_req_i | mem_req_i;
  assign winner_o  = (mem_req_i && !if_forced) ? OWN_MEM : OWN_IF;

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one synchronous-read RAM between IF fetch (read-only) and MEM
// load/store. One transaction at a time through IDLE/ACCESS/RDATA/DONE.
module imem_dmem_port_arbiter
  import imem_dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int ADDR_W       = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_over_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic [3:0]        mem_wen_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_over_o,
  output logic [31:0]       mem_rdata_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_wen_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              owner_o,
  output logic [1:0]        state_o,
  output logic [3:0]        starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a requester holds req (and its addr/data) until it sees its
  // over; over then stays high until req drops. Dropping req before over
  // cancels the access with no over pulse and no rdata update.

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic              if_over_q, if_over_d;
  logic              mem_over_q, mem_over_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic grant;
  logic winner;
  logic owner_req;

  port_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .if_req_i    (if_req_i),
    .mem_req_i   (mem_req_i),
    .starve_cnt_i(starve_q),
    .grant_o     (grant),
    .winner_o    (winner)
  );

  assign owner_req = (owner_q == OWN_MEM) ? mem_req_i : if_req_i;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    if_over_d   = if_over_q;
    mem_over_d  = mem_over_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_en_d    = ram_en_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        ram_en_d  = 1'b0;
        ram_wen_d = 4'd0;
        if (grant) begin
          state_d  = ST_ACCESS;
          owner_d  = winner;
          ram_en_d = 1'b1;
          if (winner == OWN_MEM) begin
            ram_wen_d   = mem_wen_i;
            ram_addr_d  = mem_addr_i;
            ram_wdata_d = mem_wdata_i;
            // Only MEM wins taken while IF waits count towards starvation.
            if (if_req_i) begin
              starve_d = (starve_q == LIMIT) ? starve_q : 4'(starve_q + 4'd1);
            end else begin
              starve_d = 4'd0;
            end
          end else begin
            ram_wen_d   = 4'd0;
            ram_addr_d  = if_addr_i;
            ram_wdata_d = 32'd0;
            starve_d    = 4'd0;
          end
        end
      end
      ST_ACCESS: begin
        ram_en_d  = 1'b0;
        ram_wen_d = 4'd0;
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else if (ram_wen_q != 4'd0) begin
          state_d    = ST_DONE;
          mem_over_d = 1'b1;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = ram_rdata_i;
            mem_over_d  = 1'b1;
          end else begin
            if_rdata_d = ram_rdata_i;
            if_over_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!owner_req) begin
          state_d    = ST_IDLE;
          if_over_d  = 1'b0;
          mem_over_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= 4'd0;
      if_over_q   <= 1'b0;
      mem_over_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 4'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      if_over_q   <= if_over_d;
      mem_over_q  <= mem_over_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign if_over_o    = if_over_q;
  assign if_rdata_o   = if_rdata_q;
  assign mem_over_o   = mem_over_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign ram_en_o     = ram_en_q;
  assign ram_wen_o    = ram_wen_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign owner_o      = owner_q;
  assign state_o      = state_q;
  assign starve_cnt_o = starve_q;

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Bench for imem_dmem_port_arbiter: RAM responder, transaction-level model,
// per-cycle compare, directed scenarios and a randomized traffic phase.
module tb_imem_dmem_port_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_over;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_over;
  logic [31:0] mem_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        owner;
  logic [1:0]  state;
  logic [3:0]  starve_cnt;

  imem_dmem_port_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_over_o   (if_over),
    .if_rdata_o  (if_rdata),
    .mem_req_i   (mem_req),
    .mem_wen_i   (mem_wen),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_over_o  (mem_over),
    .mem_rdata_o (mem_rdata),
    .ram_en_o    (ram_en),
    .ram_wen_o   (ram_wen),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .owner_o     (owner),
    .state_o     (state),
    .starve_cnt_o(starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // ---------------- RAM responder (driven by DUT outputs) ----------------
  logic [31:0] ram_mem [256];
  logic        r_en;
  logic [3:0]  r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  always @(negedge clk) begin
    r_en    = ram_en;
    r_wen   = ram_wen;
    r_addr  = ram_addr;
    r_wdata = ram_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (r_en === 1'b1) begin
      if (r_wen != 4'd0) ram_mem[r_addr[9:2]] = merge(ram_mem[r_addr[9:2]], r_wdata, r_wen);
      else               ram_rdata = ram_mem[r_addr[9:2]];
    end
  end

  // ---------------- transaction-level model ----------------
  logic [31:0] m_mem [256];
  bit          m_seen = 0;
  bit          m_active;
  bit          m_who;
  int          m_phase;   // cycles since grant: 1 RAM enabled, 2 data returning, 3 over held
  bit          m_store;
  logic [31:0] m_addr;
  int          m_cnt;
  logic        e_if_over, e_mem_over, e_ram_en, e_owner;
  logic [31:0] e_if_rdata, e_mem_rdata, e_ram_addr, e_ram_wdata;
  logic [3:0]  e_ram_wen;

  always @(posedge clk) begin
    bit oreq;
    if (!resetn) begin
      m_seen = 1; m_active = 0; m_who = 0; m_phase = 0; m_store = 0; m_cnt = 0;
      e_if_over = 0; e_mem_over = 0; e_ram_en = 0; e_owner = 0;
      e_if_rdata = 0; e_mem_rdata = 0; e_ram_addr = 0; e_ram_wdata = 0; e_ram_wen = 0;
    end else if (m_seen) begin
      oreq = m_who ? mem_req : if_req;
      if (!m_active) begin
        e_ram_en = 0; e_ram_wen = 0;
        if (if_req || mem_req) begin
          m_who = mem_req && !(if_req && m_cnt == LIM);
          m_active = 1; m_phase = 1; e_ram_en = 1; e_owner = m_who;
          if (m_who) begin
            m_cnt = if_req ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
            m_addr = mem_addr; m_store = (mem_wen != 0);
            e_ram_wen = mem_wen; e_ram_addr = mem_addr; e_ram_wdata = mem_wdata;
            // A granted store always reaches the RAM, even if cancelled later.
            if (m_store) m_mem[mem_addr[9:2]] = merge(m_mem[mem_addr[9:2]], mem_wdata, mem_wen);
          end else begin
            m_cnt = 0; m_addr = if_addr; m_store = 0;
            e_ram_wen = 0; e_ram_addr = if_addr;
          end
        end
      end else begin
        case (m_phase)
          1: begin
            e_ram_en = 0; e_ram_wen = 0;
            if (!oreq) m_active = 0;
            else if (m_store) begin m_phase = 3; e_mem_over = 1; end
            else m_phase = 2;
          end
          2: begin
            if (!oreq) m_active = 0;
            else begin
              m_phase = 3;
              if (m_who) begin e_mem_rdata = m_mem[m_addr[9:2]]; e_mem_over = 1; end
              else       begin e_if_rdata  = m_mem[m_addr[9:2]]; e_if_over  = 1; end
            end
          end
          default: begin
            if (!oreq) begin m_active = 0; e_if_over = 0; e_mem_over = 0; end
          end
        endcase
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_seen) begin
      check("if_over",    32'(if_over),    32'(e_if_over));
      check("mem_over",   32'(mem_over),   32'(e_mem_over));
      check("if_rdata",   if_rdata,        e_if_rdata);
      check("mem_rdata",  mem_rdata,       e_mem_rdata);
      check("ram_en",     32'(ram_en),     32'(e_ram_en));
      check("ram_wen",    32'(ram_wen),    32'(e_ram_wen));
      check("owner",      32'(owner),      32'(e_owner));
      check("state",      32'(state),      m_active ? 32'(m_phase) : 32'd0);
      check("starve_cnt", 32'(starve_cnt), 32'(m_cnt));
      if (e_ram_en) check("ram_addr", ram_addr, e_ram_addr);
      if (e_ram_en && e_ram_wen != 0) check("ram_wdata", ram_wdata, e_ram_wdata);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  mem_grants;
    bit  if_granted;
    int  if_hold, mem_hold;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    ram_mem[32'h34 >> 2] = 32'h2401_0001;
    ram_mem[32'h40 >> 2] = 32'h1111_2222;
    for (int i = 0; i < 256; i++) m_mem[i] = ram_mem[i];

    resetn = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_wen = 0;
    mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
    repeat (3) @(posedge clk);
    #2 resetn = 1;
    neg(1);
    check("rst_if_over", 32'(if_over), 32'd0);
    check("rst_ram_en",  32'(ram_en),  32'd0);
    check("rst_owner",   32'(owner),   32'd0);
    check("rst_state",   32'(state),   32'd0);
    check("rst_rdata",   if_rdata,     32'd0);

    // Lone fetch
    drive_edge(); if_req = 1; if_addr = 32'h34;
    neg(1); neg(1);
    check("fetch_c1_ram_en",   32'(ram_en), 32'd1);
    check("fetch_c1_ram_addr", ram_addr,    32'h34);
    neg(2);
    check("fetch_c3_over",  32'(if_over), 32'd1);
    check("fetch_c3_rdata", if_rdata,     32'h2401_0001);
    drive_edge(); if_req = 0;
    neg(1); check("fetch_over_hold", 32'(if_over), 32'd1);
    neg(1); check("fetch_over_clr",  32'(if_over), 32'd0);
    check("fetch_idle", 32'(state), 32'd0);

    // Store then load
    drive_edge(); mem_req = 1; mem_wen = 4'hF; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    neg(1); neg(1);
    check("store_c1_wen",   32'(ram_wen), 32'hF);
    check("store_c1_wdata", ram_wdata,    32'hDEAD_BEEF);
    neg(1); check("store_c2_over", 32'(mem_over), 32'd1);
    drive_edge(); mem_req = 0;
    neg(2); check("store_over_clr", 32'(mem_over), 32'd0);
    drive_edge(); mem_req = 1; mem_wen = 0;
    neg(1); neg(3);
    check("load_c3_over",  32'(mem_over), 32'd1);
    check("load_c3_rdata", mem_rdata,     32'hDEAD_BEEF);
    drive_edge(); mem_req = 0;
    neg(2);

    // Contention: MEM first, then IF
    drive_edge(); if_req = 1; if_addr = 32'h34; mem_req = 1; mem_wen = 0; mem_addr = 32'h100;
    neg(1); neg(1);
    check("cont_owner_mem", 32'(owner),      32'd1);
    check("cont_cnt1",      32'(starve_cnt), 32'd1);
    neg(2);
    check("cont_mem_over", 32'(mem_over), 32'd1);
    check("cont_if_wait",  32'(if_over),  32'd0);
    drive_edge(); mem_req = 0;
    neg(2); check("cont_gap_idle", 32'(state), 32'd0);
    neg(1); check("cont_if_grant", 32'(owner), 32'd0);
    check("cont_cnt_clr", 32'(starve_cnt), 32'd0);
    neg(2); check("cont_if_over", 32'(if_over), 32'd1);
    drive_edge(); if_req = 0;
    neg(2);

    // Starvation: MEM re-requests back-to-back while IF waits
    drive_edge(); if_req = 1; if_addr = 32'h34; mem_req = 1; mem_wen = 0; mem_addr = 32'h100;
    mem_grants = 0; if_granted = 0;
    for (int k = 0; k < 80 && !if_granted; k++) begin
      @(negedge clk);
      if (ram_en === 1'b1 && state == 2'd1) begin
        if (owner === 1'b1) begin
          mem_grants++;
          if (mem_grants == LIM) check("starve_cnt_sat", 32'(starve_cnt), 32'(LIM));
        end else begin
          if_granted = 1;
          check("starve_cnt_after_if", 32'(starve_cnt), 32'd0);
        end
      end
      if (!if_granted) begin
        drive_edge();
        mem_req = !(mem_over === 1'b1);
      end
    end
    check("starve_if_granted", 32'(if_granted), 32'd1);
    check("starve_mem_grants", 32'(mem_grants), 32'(LIM));
    drive_edge(); mem_req = 0;
    neg(1); neg(1);
    check("starve_if_over", 32'(if_over), 32'd1);
    drive_edge(); if_req = 0;
    neg(2);

    // Cancel a fetch in RDATA, pending MEM then granted
    drive_edge(); if_req = 1; if_addr = 32'h40;
    neg(1);
    drive_edge(); mem_req = 1; mem_wen = 0; mem_addr = 32'h100;
    neg(1); check("cancel_if_owner", 32'(owner), 32'd0);
    drive_edge(); if_req = 0;
    neg(1); neg(1);
    check("cancel_no_over",  32'(if_over), 32'd0);
    check("cancel_rdata",    if_rdata,     32'h2401_0001);
    check("cancel_idle",     32'(state),   32'd0);
    neg(1);
    check("cancel_mem_en",    32'(ram_en), 32'd1);
    check("cancel_mem_owner", 32'(owner),  32'd1);
    neg(2); check("cancel_mem_over", 32'(mem_over), 32'd1);
    drive_edge(); mem_req = 0;
    neg(2);

    // Reset during RDATA
    drive_edge(); if_req = 1; if_addr = 32'h40;
    neg(1); neg(1);
    drive_edge(); resetn = 0;
    neg(1); neg(1);
    check("rst_mid_if_over",   32'(if_over), 32'd0);
    check("rst_mid_if_rdata",  if_rdata,     32'd0);
    check("rst_mid_mem_rdata", mem_rdata,    32'd0);
    check("rst_mid_ram_en",    32'(ram_en),  32'd0);
    check("rst_mid_ram_addr",  ram_addr,     32'd0);
    check("rst_mid_owner",     32'(owner),   32'd0);
    check("rst_mid_state",     32'(state),   32'd0);
    drive_edge(); resetn = 1;
    neg(1); neg(3);
    check("post_rst_over",  32'(if_over), 32'd1);
    check("post_rst_rdata", if_rdata,     32'h1111_2222);
    drive_edge(); if_req = 0;
    neg(2);

    // Randomized traffic
    if_hold = 0; mem_hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive_edge();
      if (!if_req) begin
        if ($urandom_range(0, 3) == 0) begin
          if_req  = 1;
          if_addr = 32'($urandom_range(0, 255)) << 2;
          if_hold = $urandom_range(0, 2);
        end
      end else if (if_over === 1'b1) begin
        if (if_hold == 0) if_req = 0; else if_hold--;
      end else if ($urandom_range(0, 40) == 0) begin
        if_req = 0;
      end
      if (!mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          mem_req   = 1;
          mem_addr  = 32'($urandom_range(0, 255)) << 2;
          mem_wen   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          mem_wdata = $urandom;
          mem_hold  = $urandom_range(0, 2);
        end
      end else if (mem_over === 1'b1) begin
        if (mem_hold == 0) mem_req = 0; else mem_hold--;
      end else if ($urandom_range(0, 40) == 0) begin
        mem_req = 0;
      end
    end
    drive_edge(); if_req = 0; mem_req = 0;
    neg(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported, synchronous-read RAM (1-cycle read latency) between two requesters: the IF fetch stage (read-only) and the MEM stage (load/store).
- Sits between fetch/mem stages and the unified RAM.
- Each requester sees a level req / sticky over handshake, matching the stage valid/over pipeline protocol.
- MEM has priority. A starvation counter guarantees IF forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive MEM grants allowed while if_req is pending before IF is forced to win. Legal range 1..15.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- if_req  in  1  IF read request; held until if_over is seen or the fetch is cancelled
- if_addr  in  ADDR_W  IF fetch address
- if_over  out  1  IF read complete; if_rdata valid
- if_rdata  out  32  fetched instruction
- mem_req  in  1  MEM access request; held like if_req
- mem_wen  in  4  byte write enables; 0 means load
- mem_addr  in  ADDR_W  MEM byte address
- mem_wdata  in  32  store data
- mem_over  out  1  MEM access complete
- mem_rdata  out  32  load data
- ram_en  out  1  RAM enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid 1 cycle after the edge that samples ram_addr
- owner  out  1  current/last grant: 0 = IF, 1 = MEM (debug)

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; all outputs 0 (if_over, mem_over, rdata regs, ram_* regs, owner); starve_cnt=0. Reset mid-access aborts with no over pulse. A store whose ram_wen edge already occurred stays committed.
- All ram_* outputs and *_over/*_rdata are registered.
- States: IDLE, ACCESS, RDATA, DONE.
- IDLE:
  - Arbitrate among asserted requests.
  - Winner is MEM, except IF wins when if_req=1 and starve_cnt==STARVE_LIMIT, or when mem_req=0.
  - On a grant, at the edge: latch the winner's addr into ram_addr, set ram_en=1, set ram_wen=mem_wen (0 for IF), set ram_wdata, set owner, then go to ACCESS.
  - With no request, stay in IDLE with ram_en=0.
- ACCESS: RAM samples at the end of this cycle. At the edge, clear ram_en/ram_wen.
  - Store (ram_wen!=0): go to DONE, set mem_over=1.
  - Otherwise: go to RDATA.
- RDATA: ram_rdata is valid. At the edge, capture it into if_rdata or mem_rdata per owner, set that requester's *_over=1, and go to DONE.
- DONE: *_over is held high while the owner's req stays 1. When the owner drops req, clear *_over at the next edge and return to IDLE. The other requester's over is never asserted.
- Latency from req high in IDLE (cycle 0):
  - Load/fetch: over high in cycle 3.
  - Store: over high in cycle 2.
- Cancel: if the owner drops req in ACCESS or RDATA, go to IDLE at the next edge. No over, no rdata update. A store is already committed once its ACCESS edge has passed.
- A new request is never granted in the same cycle a transaction ends. Minimum spacing between grants is 1 IDLE cycle.
- Starvation counter:
  - Increment (saturating at STARVE_LIMIT) on each MEM grant made while if_req=1.
  - Clear on each IF grant, or when a MEM grant is made with if_req=0.
- Simultaneous requests in IDLE with starve_cnt<STARVE_LIMIT: MEM wins and IF waits with its request held.
- Addresses are passed unmodified. Alignment is the requester's responsibility. rdata regs retain their last value when not updated.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, RDATA=2'd2, DONE=2'd3), owner codes OWN_IF=1'b0 / OWN_MEM=1'b1, and the STARVE_LIMIT default.
- One natural sub-module, port_arb_pick: purely combinational winner select from if_req, mem_req and starve_cnt. Everything else lives in the top FSM.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x34, RAM[0x34]=0x24010001 -> ram_en=1 / ram_addr=0x34 in cycle 1; if_over=1 and if_rdata=0x24010001 in cycle 3; if_over clears one cycle after if_req drops.
- Store then load: mem_req with mem_wen=4'b1111, addr=0x100, wdata=0xDEADBEEF -> mem_over in cycle 2. After the drop, a load from 0x100 -> mem_rdata=0xDEADBEEF in cycle 3.
- Contention: if_req and mem_req both high from cycle 0 -> MEM granted first, if_over stays 0. After mem_req drops, IF is granted and if_over rises.
- Starvation with STARVE_LIMIT=4: if_req held, MEM re-requests back-to-back -> exactly 4 MEM grants, then an IF grant even though mem_req=1; starve_cnt returns to 0.
- Cancel: fetch granted, if_req dropped in RDATA -> no if_over pulse, if_rdata unchanged, state back to IDLE the next cycle. A pending mem_req is then granted.
- Reset mid-access: resetn=0 during RDATA -> next cycle all outputs 0 and state IDLE. After release, a new fetch completes with normal 3-cycle latency.
